// File: rtl/param_register_file.sv
// Parametrised register file: NUM_RD registered read ports with write bypass and a
// per-register pending bit that decode uses to detect RAW hazards.
module param_register_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  input  logic                       flush,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pending,
  output logic [(2**ADDR_W)-1:0]     pending_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic              wr_ok;
  logic              alloc_ok;

  logic [ADDR_W-1:0] rd_addr_a  [NUM_RD];
  logic [DATA_W-1:0] rd_byp     [NUM_RD];
  logic [DATA_W-1:0] rd_data_q  [NUM_RD];
  logic              rd_pend_q  [NUM_RD];

  assign wr_ok    = wr_en && (wr_addr != '0);
  assign alloc_ok = alloc_en && (alloc_addr != '0);

  // Ordering encodes priority: write clears, a same-cycle alloc re-sets, flush beats both.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok)    pending_d[wr_addr]    = 1'b0;
    if (alloc_ok) pending_d[alloc_addr] = 1'b1;
    if (flush)    pending_d             = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      pending_q <= pending_d;
      if (wr_ok) regs[wr_addr] <= wr_data;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_port
      assign rd_addr_a[g]                   = rd_addr[g*ADDR_W +: ADDR_W];
      assign rd_data[g*DATA_W +: DATA_W]    = rd_data_q[g];
      assign rd_pending[g]                  = rd_pend_q[g];
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_byp[k] = regs[rd_addr_a[k]];
      if (rd_addr_a[k] == '0)                    rd_byp[k] = '0;
      else if (wr_en && wr_addr == rd_addr_a[k]) rd_byp[k] = wr_data;
    end
  end

  // Read pending reflects the post-edge scoreboard so decode sees this cycle's issue/write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_RD; k++) begin
        rd_data_q[k] <= '0;
        rd_pend_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        rd_data_q[k] <= rd_byp[k];
        rd_pend_q[k] <= pending_d[rd_addr_a[k]];
      end
    end
  end

  assign pending_vec = pending_q;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: a default 8x8/2-port instance and a 16x16/4-port instance
// driven side by side and checked against array-based reference models.
module tb_param_register_file;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        alloc_en;
  logic [3:0]  alloc_addr;
  logic        flush;
  logic [3:0]  rd_addr [4];

  logic [5:0]  n_rd_addr;
  logic [15:0] n_rd_data;
  logic [1:0]  n_rd_pending;
  logic [7:0]  n_pending_vec;

  logic [15:0] w_rd_addr;
  logic [63:0] w_rd_data;
  logic [3:0]  w_rd_pending;
  logic [15:0] w_pending_vec;

  assign n_rd_addr = {rd_addr[1][2:0], rd_addr[0][2:0]};
  assign w_rd_addr = {rd_addr[3], rd_addr[2], rd_addr[1], rd_addr[0]};

  param_register_file #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) u_dut_n (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr[2:0]),
    .wr_data     (wr_data[7:0]),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr[2:0]),
    .flush       (flush),
    .rd_addr     (n_rd_addr),
    .rd_data     (n_rd_data),
    .rd_pending  (n_rd_pending),
    .pending_vec (n_pending_vec)
  );

  param_register_file #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) u_dut_w (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .flush       (flush),
    .rd_addr     (w_rd_addr),
    .rd_data     (w_rd_data),
    .rd_pending  (w_rd_pending),
    .pending_vec (w_pending_vec)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: index 0 = narrow instance, 1 = wide instance
  logic [15:0] m_reg  [2][16];
  logic        m_pend [2][16];
  logic [16:0] exp_q [$];
  int          n_cmp;
  int          n_fail;

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        m_reg[d][i]  = '0;
        m_pend[d][i] = 1'b0;
      end
    exp_q.delete();
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic [3:0]  am;
      logic [3:0]  wa;
      logic [3:0]  aa;
      logic [3:0]  ra;
      logic [15:0] dm;
      logic [15:0] wd;
      logic [15:0] rv;
      logic        np [16];
      int          nr;
      am = (d == 1) ? 4'hF : 4'h7;
      dm = (d == 1) ? 16'hFFFF : 16'h00FF;
      nr = (d == 1) ? 4 : 2;
      wa = wr_addr & am;
      aa = alloc_addr & am;
      wd = wr_data & dm;
      for (int i = 0; i < 16; i++) np[i] = m_pend[d][i];
      if (wr_en && wa != 0)    np[wa] = 1'b0;
      if (alloc_en && aa != 0) np[aa] = 1'b1;
      if (flush) for (int i = 0; i < 16; i++) np[i] = 1'b0;
      for (int k = 0; k < nr; k++) begin
        ra = rd_addr[k] & am;
        if (ra == 0)                     rv = '0;
        else if (wr_en && wa == ra)      rv = wd;
        else                             rv = m_reg[d][ra];
        exp_q.push_back({np[ra] && (ra != 0), rv});
      end
      if (wr_en && wa != 0) m_reg[d][wa] = wd;
      for (int i = 0; i < 16; i++) m_pend[d][i] = np[i];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [16:0] e;
      logic [16:0] o;
      logic [15:0] pv;
      logic [15:0] opv;
      int          nr;
      nr = (d == 1) ? 4 : 2;
      for (int k = 0; k < nr; k++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
        if (d == 1) o = {w_rd_pending[k], w_rd_data[k*16 +: 16]};
        else        o = {n_rd_pending[k], 8'h00, n_rd_data[k*8 +: 8]};
        check($sformatf("%s d%0d port%0d", tag, d, k), {15'b0, o}, {15'b0, e});
      end
      pv = '0;
      for (int i = 0; i < ((d == 1) ? 16 : 8); i++) pv[i] = m_pend[d][i];
      opv = (d == 1) ? w_pending_vec : {8'h00, n_pending_vec};
      check($sformatf("%s d%0d pending_vec", tag, d), {16'b0, opv}, {16'b0, pv});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " n_rd_data"},     {16'b0, n_rd_data},     32'h0);
    check({tag, " n_rd_pending"},  {30'b0, n_rd_pending},  32'h0);
    check({tag, " n_pending_vec"}, {24'b0, n_pending_vec}, 32'h0);
    check({tag, " w_rd_data_lo"},  w_rd_data[31:0],        32'h0);
    check({tag, " w_rd_data_hi"},  w_rd_data[63:32],       32'h0);
    check({tag, " w_rd_pending"},  {28'b0, w_rd_pending},  32'h0);
    check({tag, " w_pending_vec"}, {16'b0, w_pending_vec}, 32'h0);
  endtask

  // Driver tasks
  task automatic idle_inputs();
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    flush      = 1'b0;
  endtask

  task automatic set_reads(input logic [3:0] a);
    for (int k = 0; k < 4; k++) rd_addr[k] = a;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    idle_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    set_reads(4'd0);
    model_reset();

    // Reset asserted away from any clock edge must clear outputs at once
    #1 rst = 1'b0;
    #1 check_zero("reset_async");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    for (int a = 1; a < 8; a++) begin
      set_reads(4'(a));
      step($sformatf("reset_read a%0d", a));
    end

    // Write with same-cycle bypass, then plain read on another port
    set_reads(4'd0);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00A5; rd_addr[0] = 4'd3;
    step("bypass");
    rd_addr[1] = 4'd3;
    step("read_after_write");

    // Register zero ignores writes and allocs
    set_reads(4'd0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h00FF;
    alloc_en = 1'b1; alloc_addr = 4'd0;
    step("zero_wr_alloc");
    step("zero_read");

    // Scoreboard: alloc, write-back clears, write+alloc re-sets
    alloc_en = 1'b1; alloc_addr = 4'd5;
    step("alloc5");
    set_reads(4'd5);
    step("read_pending5");
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h003C;
    step("writeback5");
    step("read5");
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0077;
    alloc_en = 1'b1; alloc_addr = 4'd5;
    step("wr_alloc5");
    step("read5_again");

    // Flush beats a same-cycle alloc
    set_reads(4'd2);
    rd_addr[1] = 4'd7;
    alloc_en = 1'b1; alloc_addr = 4'd2; step("alloc2");
    alloc_en = 1'b1; alloc_addr = 4'd4; step("alloc4");
    alloc_en = 1'b1; alloc_addr = 4'd6; step("alloc6");
    rd_addr[0] = 4'd7; rd_addr[1] = 4'd6;
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 4'd7;
    step("flush_alloc7");

    // Async reset mid-cycle with live state in reg 4
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0011;
    alloc_en = 1'b1; alloc_addr = 4'd4;
    step("setup4");
    set_reads(4'd4);
    step("read4");
    #2 rst = 1'b0;
    model_reset();
    #1 check_zero("midcycle_reset");
    @(posedge clk);
    #1 check_zero("reset_held");
    #2 rst = 1'b1;
    set_reads(4'd4);
    step("read4_after_reset");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 4'($urandom_range(0, 15));
      wr_data    = 16'($urandom_range(0, 65535));
      alloc_en   = 1'($urandom_range(0, 1));
      alloc_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      flush      = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 4; k++)
        rd_addr[k] = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      step($sformatf("rand%0d", n));
    end

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Parametrised multi-read-port register file for the pipelined datapath. It replaces the fixed 8x8, two-read-port file used in decode. It adds configurable width, depth and read-port count, registered posedge reads with write-to-read bypass, and a per-register pending (scoreboard) bit. Decode uses the pending bit to detect RAW hazards against in-flight producers.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, address width; depth = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous reset, active-low
wr_en  input  1  write-back enable
wr_addr  input  ADDR_W  write-back destination
wr_data  input  DATA_W  write-back data
alloc_en  input  1  mark a destination as pending (instruction issued)
alloc_addr  input  ADDR_W  destination being allocated
flush  input  1  clear all pending bits (pipeline flush)
rd_addr  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W]
rd_pending  output  NUM_RD  registered pending flag per read port
pending_vec  output  2**ADDR_W  current pending bit of every register (debug/stall logic)

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all pending bits = 0, rd_data = 0, rd_pending = 0. Effect is immediate, not clock-gated. Deassertion is sampled at the next posedge. Reset mid-write discards the write.
- Register 0 is hardwired zero. Writes to address 0 are ignored. Allocating address 0 is ignored. pending_vec[0] is always 0. A read of address 0 returns 0 with rd_pending=0.
- Write: on posedge, if wr_en and wr_addr!=0, then reg[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Allocate: on posedge, if alloc_en and alloc_addr!=0, then pending[alloc_addr] <= 1.
- Simultaneous write and alloc to the same address in one cycle: the data is written and the pending bit ends at 1, because the newer producer wins.
- flush: on posedge, all pending bits <= 0. flush has priority over alloc in the same cycle; the write still completes.
- Read: latency is 1 cycle. On each posedge, per port k:
  - rd_data[k] <= (addr==0) ? 0 : (wr_en && wr_addr==addr) ? wr_data : reg[addr]
  - rd_pending[k] <= next-state pending[addr], i.e. the value after this edge's write/alloc/flush is applied.
  - Bypass takes precedence over array contents. Ports are fully independent, and any number of ports may read the same address.
- pending_vec is the current registered pending state. It has no combinational path from inputs.
- No X propagation: out-of-range addresses cannot occur (depth = 2**ADDR_W).
- Width rules: all data paths are exactly DATA_W. No sign extension, no truncation.

Test Plan:
- Reset then read: hold rst=0 for 2 cycles, release, read addr 1..7 on all ports -> rd_data=0, rd_pending=0, pending_vec=0.
- Write/read with bypass (DATA_W=8): wr_en=1, wr_addr=3, wr_data=8'hA5 and rd_addr port0=3 in the same cycle -> after that edge rd_data port0=8'hA5. Next cycle, read addr 3 on port1 -> 8'hA5.
- Zero register: write 8'hFF to addr 0 and alloc addr 0, then read addr 0 -> rd_data=0, rd_pending=0, pending_vec[0]=0.
- Scoreboard: alloc addr 5, read addr 5 next cycle -> rd_pending=1 and pending_vec[5]=1. Write addr 5 with 8'h3C -> pending_vec[5]=0 and a read returns 8'h3C with rd_pending=0. Write+alloc addr 5 in the same cycle -> pending_vec[5]=1 and data updated.
- Flush: alloc addrs 2, 4, 6 on successive cycles, then flush=1 together with alloc addr 7 -> pending_vec=0 after the edge.
- Async reset mid-operation: drive rst=0 between clock edges while reg 4 = 8'h11 and pending[4]=1 -> rd_data, pending_vec and the array clear immediately without waiting for a clock edge. Repeat the full run with NUM_RD=4, DATA_W=16, ADDR_W=4.
